pipe_ctrl: RTL

- Consumer end of the hazard/stall interface. Takes stall, flush, halt and memory-busy requests and turns them into per-stage pipeline-register enables, bubble and flush controls, and a halted status.
- Sits between the hazard detect unit, the EX-stage branch resolver and the five pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) of the 16-bit pipelined core.
- Resolves simultaneous requests by fixed priority and sequences multi-cycle stalls and the drain to halt.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_stall_counter.sv | 41 ++++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline control block
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF        = 3;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int PERF_W_DEF       = 16;

  // Instruction word loaded into a pipeline register when it is bubbled or flushed.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GRP_NORMAL  = 2'd0,
    GRP_STALLED = 2'd1,
    GRP_FROZEN  = 2'd2,
    GRP_FLUSH   = 2'd3
  } grp_e;

  // {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, bubble_ID_EX, flush_IF_ID}
  function automatic logic [6:0] grp_controls(grp_e grp);
    logic [6:0] ctl;
    ctl = 7'b0000000;
    case (grp)
      GRP_NORMAL:  ctl = 7'b1111100;
      GRP_STALLED: ctl = 7'b0011110;
      GRP_FROZEN:  ctl = 7'b0000000;
      GRP_FLUSH:   ctl = 7'b1111111;
      default:     ctl = 7'b0000000;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_counter.sv
// rtl/pipe_ctrl_stall_counter.sv - loadable, holdable down-counter shared by STALL and DRAIN
module stall_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Decrement stops at zero so the count can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/halt sequencer driving pipeline register controls; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int PERF_W       = PERF_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic [CNT_W-1:0] stall_len,
  input  logic             flush_req,
  input  logic             halt_req,
  input  logic             mem_busy,
  output logic             en_PC,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
`endif
  output logic             halted
);

  if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES >= (1 << CNT_W)) || (PERF_W < 1)) begin : g_bad_params
    $error("pipe_ctrl: DRAIN_CYCLES must fit in CNT_W bits and PERF_W must be positive");
  end

  state_e           state_q;
  state_e           state_d;
  grp_e             grp;
  logic             halted_q;
  logic             cnt_clr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_one;
  logic [CNT_W-1:0] eff_len;
  logic [6:0]       ctl;

  assign eff_len = (stall_len == '0) ? CNT_W'(1) : stall_len;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .one_o      (cnt_one)
  );

  // Fixed priority: halted > mem_busy > flush_req > stall_req > halt_req.
  always_comb begin
    state_d      = state_q;
    grp          = GRP_NORMAL;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (state_q == ST_HALTED) begin
      grp = GRP_FROZEN;
    end else if (mem_busy) begin
      grp = GRP_FROZEN;
    end else if (flush_req) begin
      grp     = GRP_FLUSH;
      state_d = ST_RUN;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stall_req) begin
            grp = GRP_STALLED;
            if (eff_len > CNT_W'(1)) begin
              cnt_load     = 1'b1;
              cnt_load_val = eff_len - CNT_W'(1);
              state_d      = ST_STALL;
            end
          end else if (halt_req) begin
            grp          = GRP_STALLED;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(DRAIN_CYCLES);
            state_d      = ST_DRAIN;
          end
        end
        ST_STALL: begin
          grp     = GRP_STALLED;
          cnt_dec = 1'b1;
          if (cnt_one) begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          grp     = GRP_STALLED;
          cnt_dec = 1'b1;
          if (cnt_one) begin
            state_d = ST_HALTED;
          end
        end
        default: begin
          grp     = GRP_FROZEN;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // Controls are forced inactive while reset is held so no register loads garbage.
  always_comb begin
    ctl = grp_controls(grp);
    if (!rst_n) begin
      ctl = 7'b0000000;
    end
    {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, bubble_ID_EX, flush_IF_ID} = ctl;
  end

  assign halted = halted_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((grp == GRP_STALLED) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if ((grp == GRP_FLUSH) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
